// File: rtl/tinymos6502_pkg.sv
// Shared types and default vectors for the tinymos6502 interrupt/reset sequencer.
package tinymos6502_pkg;

  typedef enum logic [1:0] {
    SVC_RESET = 2'd0,
    SVC_NMI   = 2'd1,
    SVC_IRQ   = 2'd2,
    SVC_BRK   = 2'd3
  } svc_kind_t;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_IDLE  = 2'd1,
    S_REQ   = 2'd2
  } seq_state_t;

  localparam logic [15:0] DEF_NMI_VEC   = 16'hFFFA;
  localparam logic [15:0] DEF_RESET_VEC = 16'hFFFC;
  localparam logic [15:0] DEF_IRQ_VEC   = 16'hFFFE;
  localparam logic [15:0] DEF_IRQ_TABLE = 16'hFFE0;

  // Width of a channel index; a single channel still gets a 1-bit field.
  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_sequencer_prio_enc.sv
// Lowest-index-first priority encoder: bit 0 has the highest priority.
module prio_enc
  import tinymos6502_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = src_width(N)
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt/reset sequencer for the tinymos6502 core. Decides at each
// instruction boundary whether to start a reset, NMI, IRQ or BRK service
// sequence and hands the decoder the vector, kind, source channel and the
// break bit to push.
//
// Handshake: SVC_REQ is held high in S_REQ with KIND/VECTOR/SRC/B_FLAG stable.
// The request is consumed only in a cycle where SVC_ACK and RDY are both high;
// that cycle pulses SET_I and SVC_REQ drops on the next cycle. SVC_ACK seen
// while RDY is low is ignored, so the decoder keeps it asserted until RDY.
module irq_sequencer
  import tinymos6502_pkg::*;
#(
  parameter int                N_IRQ        = 4,
  parameter int                ADDR_W       = 16,
  parameter int                VECTORED     = 0,
  parameter int                RESET_CYCLES = 2,
  parameter logic [ADDR_W-1:0] NMI_VEC      = ADDR_W'(DEF_NMI_VEC),
  parameter logic [ADDR_W-1:0] RESET_VEC    = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] IRQ_VEC      = ADDR_W'(DEF_IRQ_VEC),
  parameter logic [ADDR_W-1:0] IRQ_TABLE    = ADDR_W'(DEF_IRQ_TABLE),
  localparam int               SRC_W        = src_width(N_IRQ)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RDY,
  input  logic              NMI,
  input  logic [N_IRQ-1:0]  IRQ,
  input  logic [N_IRQ-1:0]  IRQ_MASK,
  input  logic              I_FLAG,
  input  logic              SYNC,
  input  logic              BRK,
  input  logic              SVC_ACK,
  output logic              SVC_REQ,
  output logic [1:0]        SVC_KIND,
  output logic [ADDR_W-1:0] SVC_VECTOR,
  output logic [SRC_W-1:0]  SVC_SRC,
  output logic              B_FLAG,
  output logic              SET_I,
  output logic              RESET_ACTIVE,
  output logic [1:0]        DBG_STATE
);

  localparam int              CNT_W    = $clog2(RESET_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RESET_CYCLES);

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              nmi_prev_q;
  logic              nmi_pend_q, nmi_pend_d;
  svc_kind_t         kind_q, kind_d;
  logic [ADDR_W-1:0] vec_q, vec_d;
  logic [SRC_W-1:0]  src_q, src_d;
  logic              bflag_q, bflag_d;

  logic              nmi_fall;
  logic              nmi_hit;
  logic [N_IRQ-1:0]  irq_active;
  logic              irq_any;
  logic              irq_hit;
  logic [SRC_W-1:0]  irq_idx;
  logic [ADDR_W-1:0] irq_vec;
  logic              ack_nmi;
  logic              set_i;

  // A falling NMI seen in the current cycle counts as pending immediately,
  // so an edge coinciding with a SYNC cycle is serviced right away.
  assign nmi_fall   = nmi_prev_q & ~NMI;
  assign nmi_hit    = nmi_pend_q | nmi_fall;
  assign irq_active = ~IRQ & ~IRQ_MASK;
  assign irq_hit    = irq_any & ~I_FLAG;

  prio_enc #(
    .N  (N_IRQ),
    .IW (SRC_W)
  ) u_prio_enc (
    .req   (irq_active),
    .valid (irq_any),
    .idx   (irq_idx)
  );

  // IRQ vector selection: fixed vector, or a two-byte table entry per channel.
  always_comb begin
    if (VECTORED != 0) irq_vec = IRQ_TABLE + (ADDR_W'(irq_idx) << 1);
    else               irq_vec = IRQ_VEC;
  end

  // Next-state, latched-request and NMI-pending logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    vec_d   = vec_q;
    src_d   = src_q;
    bflag_d = bflag_q;
    ack_nmi = 1'b0;
    set_i   = 1'b0;
    case (state_q)
      S_RESET: begin
        if (cnt_q == '0) state_d = S_REQ;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_IDLE: begin
        if (SYNC && RDY) begin
          if (nmi_hit) begin
            state_d = S_REQ;
            kind_d  = SVC_NMI;
            vec_d   = NMI_VEC;
            src_d   = '0;
            bflag_d = BRK;
          end else if (irq_hit) begin
            state_d = S_REQ;
            kind_d  = SVC_IRQ;
            vec_d   = irq_vec;
            src_d   = irq_idx;
            bflag_d = 1'b0;
          end else if (BRK) begin
            state_d = S_REQ;
            kind_d  = SVC_BRK;
            vec_d   = IRQ_VEC;
            src_d   = '0;
            bflag_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (SVC_ACK && RDY) begin
          set_i   = 1'b1;
          state_d = S_IDLE;
          ack_nmi = (kind_q == SVC_NMI);
        end
      end
      default: state_d = S_RESET;
    endcase
    // A new edge in the ack cycle keeps the NMI pending.
    nmi_pend_d = (nmi_pend_q & ~ack_nmi) | nmi_fall;
  end

  // State register; a low RST_N restarts the reset countdown from any state.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= S_RESET;
      cnt_q      <= CNT_INIT;
      nmi_prev_q <= 1'b1;
      nmi_pend_q <= 1'b0;
      kind_q     <= SVC_RESET;
      vec_q      <= RESET_VEC;
      src_q      <= '0;
      bflag_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nmi_prev_q <= NMI;
      nmi_pend_q <= nmi_pend_d;
      kind_q     <= kind_d;
      vec_q      <= vec_d;
      src_q      <= src_d;
      bflag_q    <= bflag_d;
    end
  end

  // Output decode: forced reset values in S_RESET, latched request otherwise.
  always_comb begin
    SVC_REQ      = (state_q == S_REQ);
    RESET_ACTIVE = (state_q == S_RESET);
    SET_I        = set_i;
    DBG_STATE    = state_q;
    SVC_KIND     = kind_q;
    SVC_VECTOR   = vec_q;
    SVC_SRC      = src_q;
    B_FLAG       = bflag_q;
    if (state_q == S_RESET) begin
      SVC_KIND   = SVC_RESET;
      SVC_VECTOR = RESET_VEC;
      SVC_SRC    = '0;
      B_FLAG     = 1'b0;
    end
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// Bench for irq_sequencer: a vectored and a fixed-vector instance share the
// same stimulus; a cycle-level reference model checks both every cycle, a
// dispatch table and hand-written sequences cover the corner cases.
module tb_irq_sequencer;
  import tinymos6502_pkg::*;

  localparam int N   = 4;
  localparam int RST = 2;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, nmi, i_flag, sync, brk, svc_ack, rdy;
  logic [N-1:0] irq, irq_mask;

  logic        v_req, v_bflag, v_set_i, v_ract;
  logic [1:0]  v_kind, v_src, v_dbg;
  logic [15:0] v_vec;
  logic        f_req, f_bflag, f_set_i, f_ract;
  logic [1:0]  f_kind, f_src, f_dbg;
  logic [15:0] f_vec;

  irq_sequencer #(.N_IRQ(N), .VECTORED(1), .RESET_CYCLES(RST)) dut_v (
    .CLK(clk), .RST_N(rst_n), .RDY(rdy), .NMI(nmi), .IRQ(irq), .IRQ_MASK(irq_mask),
    .I_FLAG(i_flag), .SYNC(sync), .BRK(brk), .SVC_ACK(svc_ack),
    .SVC_REQ(v_req), .SVC_KIND(v_kind), .SVC_VECTOR(v_vec), .SVC_SRC(v_src),
    .B_FLAG(v_bflag), .SET_I(v_set_i), .RESET_ACTIVE(v_ract), .DBG_STATE(v_dbg)
  );

  irq_sequencer #(.N_IRQ(N), .VECTORED(0), .RESET_CYCLES(RST)) dut_f (
    .CLK(clk), .RST_N(rst_n), .RDY(rdy), .NMI(nmi), .IRQ(irq), .IRQ_MASK(irq_mask),
    .I_FLAG(i_flag), .SYNC(sync), .BRK(brk), .SVC_ACK(svc_ack),
    .SVC_REQ(f_req), .SVC_KIND(f_kind), .SVC_VECTOR(f_vec), .SVC_SRC(f_src),
    .B_FLAG(f_bflag), .SET_I(f_set_i), .RESET_ACTIVE(f_ract), .DBG_STATE(f_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_valid = 1'b0;
  bit m_in_reset, m_req, m_nmi_last, m_nmi_pend, m_bflag;
  int m_cnt, m_kind, m_src, m_vec_v, m_vec_f;

  function automatic int lowest_irq();
    for (int k = 0; k < N; k++) if (!irq[k] && !irq_mask[k]) return k;
    return -1;
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit fall, clr;
    int k;
    if (!rst_n) begin
      m_valid = 1'b1; m_in_reset = 1'b1; m_req = 1'b0; m_cnt = RST;
      m_nmi_pend = 1'b0; m_nmi_last = 1'b1;
      m_kind = 0; m_vec_v = 'hFFFC; m_vec_f = 'hFFFC; m_src = 0; m_bflag = 1'b0;
      return;
    end
    if (!m_valid) return;
    fall = m_nmi_last && !nmi;
    clr  = 1'b0;
    if (m_in_reset) begin
      if (m_cnt == 0) begin m_in_reset = 1'b0; m_req = 1'b1; end
      else m_cnt--;
    end else if (m_req) begin
      if (svc_ack && rdy) begin m_req = 1'b0; clr = (m_kind == 1); end
    end else if (sync && rdy) begin
      k = lowest_irq();
      if (m_nmi_pend || fall) begin
        m_req = 1'b1; m_kind = 1; m_vec_v = 'hFFFA; m_vec_f = 'hFFFA; m_src = 0; m_bflag = brk;
      end else if (k >= 0 && !i_flag) begin
        m_req = 1'b1; m_kind = 2; m_vec_v = 'hFFE0 + 2 * k; m_vec_f = 'hFFFE; m_src = k; m_bflag = 1'b0;
      end else if (brk) begin
        m_req = 1'b1; m_kind = 3; m_vec_v = 'hFFFE; m_vec_f = 'hFFFE; m_src = 0; m_bflag = 1'b1;
      end
    end
    m_nmi_pend = (m_nmi_pend && !clr) || fall;
    m_nmi_last = nmi;
  endtask

  // Compare both instances against the model for the current cycle.
  task automatic check_model();
    int exp_dbg;
    bit exp_set_i;
    if (!m_valid) return;
    exp_set_i = m_req && svc_ack && rdy;
    exp_dbg   = m_in_reset ? int'(S_RESET) : (m_req ? int'(S_REQ) : int'(S_IDLE));
    chk("m_req_v",   32'(v_req),   32'(m_req));
    chk("m_kind_v",  32'(v_kind),  m_kind);
    chk("m_vec_v",   32'(v_vec),   m_vec_v);
    chk("m_src_v",   32'(v_src),   m_src);
    chk("m_bflag_v", 32'(v_bflag), 32'(m_bflag));
    chk("m_seti_v",  32'(v_set_i), 32'(exp_set_i));
    chk("m_ract_v",  32'(v_ract),  32'(m_in_reset));
    chk("m_dbg_v",   32'(v_dbg),   exp_dbg);
    chk("m_req_f",   32'(f_req),   32'(m_req));
    chk("m_kind_f",  32'(f_kind),  m_kind);
    chk("m_vec_f",   32'(f_vec),   m_vec_f);
    chk("m_src_f",   32'(f_src),   m_src);
    chk("m_bflag_f", 32'(f_bflag), 32'(m_bflag));
    chk("m_seti_f",  32'(f_set_i), 32'(exp_set_i));
    chk("m_ract_f",  32'(f_ract),  32'(m_in_reset));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are set just after a falling edge; one tick checks, clocks, re-aligns.
  task automatic tick();
    #1;
    check_model();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic ack_request();
    svc_ack = 1'b1;
    tick();
    svc_ack = 1'b0;
    tick();
  endtask

  // ---------------- dispatch table ----------------
  typedef struct {
    logic [3:0]  irq;
    logic [3:0]  mask;
    logic        iflag;
    logic        brk;
    logic        req;
    logic [1:0]  kind;
    logic [1:0]  src;
    logic [15:0] vec_v;
    logic [15:0] vec_f;
    logic        bflag;
  } vec_t;

  vec_t tbl[10];

  task automatic run_entry(input int i);
    irq = tbl[i].irq; irq_mask = tbl[i].mask; i_flag = tbl[i].iflag; brk = tbl[i].brk;
    sync = 1'b1; rdy = 1'b1;
    tick();
    sync = 1'b0; brk = 1'b0; irq = '1; irq_mask = '0; i_flag = 1'b0;
    chk($sformatf("tbl%0d_req", i), 32'(v_req), 32'(tbl[i].req));
    if (tbl[i].req) begin
      chk($sformatf("tbl%0d_kind", i),  32'(v_kind),  32'(tbl[i].kind));
      chk($sformatf("tbl%0d_src", i),   32'(v_src),   32'(tbl[i].src));
      chk($sformatf("tbl%0d_vec_v", i), 32'(v_vec),   32'(tbl[i].vec_v));
      chk($sformatf("tbl%0d_vec_f", i), 32'(f_vec),   32'(tbl[i].vec_f));
      chk($sformatf("tbl%0d_bflag", i), 32'(v_bflag), 32'(tbl[i].bflag));
      ack_request();
    end else begin
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    //             irq      mask     if    brk   req   kind  src   vec_v      vec_f      bflag
    tbl[0] = '{4'b0101, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 2'd1, 16'hFFE2, 16'hFFFE, 1'b0};
    tbl[1] = '{4'b0101, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd2, 2'd3, 16'hFFE6, 16'hFFFE, 1'b0};
    tbl[2] = '{4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 16'h0000, 16'h0000, 1'b0};
    tbl[3] = '{4'b1110, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 16'hFFE0, 16'hFFFE, 1'b0};
    tbl[4] = '{4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd3, 2'd0, 16'hFFFE, 16'hFFFE, 1'b1};
    tbl[5] = '{4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 16'h0000, 16'h0000, 1'b0};
    tbl[6] = '{4'b0111, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 2'd3, 16'hFFE6, 16'hFFFE, 1'b0};
    tbl[7] = '{4'b1110, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd3, 2'd0, 16'hFFFE, 16'hFFFE, 1'b1};
    tbl[8] = '{4'b1011, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 16'h0000, 16'h0000, 1'b0};
    tbl[9] = '{4'b1011, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd2, 2'd2, 16'hFFE4, 16'hFFFE, 1'b0};

    rst_n = 1'b0; nmi = 1'b1; irq = '1; irq_mask = '0; i_flag = 1'b0;
    sync = 1'b0; brk = 1'b0; svc_ack = 1'b0; rdy = 1'b1;
    @(negedge clk);

    // Reset release: request appears on the third cycle after release.
    repeat (3) tick();
    chk("rst_active_low", 32'(v_ract), 32'd1);
    chk("rst_req_low",    32'(v_req),  32'd0);
    chk("rst_vec_low",    32'(v_vec),  32'hFFFC);
    rst_n = 1'b1;
    tick();
    tick();
    chk("rst_active_2", 32'(v_ract), 32'd1);
    chk("rst_req_2",    32'(v_req),  32'd0);
    tick();
    chk("rst_active_3", 32'(v_ract), 32'd0);
    chk("rst_req_3",    32'(v_req),  32'd1);
    chk("rst_kind_3",   32'(v_kind), 32'd0);
    chk("rst_vec_3",    32'(f_vec),  32'hFFFC);
    svc_ack = 1'b1;
    #1 chk("rst_set_i", 32'(v_set_i), 32'd1);
    tick();
    svc_ack = 1'b0;
    chk("rst_idle_req", 32'(v_req), 32'd0);
    tick();

    // NMI falling while stalled, held low: exactly one service.
    rdy = 1'b0; nmi = 1'b0;
    repeat (6) tick();
    rdy = 1'b1;
    repeat (4) tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("nmi_req",  32'(v_req),  32'd1);
    chk("nmi_kind", 32'(v_kind), 32'd1);
    chk("nmi_vec",  32'(v_vec),  32'hFFFA);
    ack_request();
    for (int i = 0; i < 6; i++) begin
      sync = 1'b1;
      tick();
      sync = 1'b0;
      chk("nmi_once", 32'(v_req), 32'd0);
      tick();
    end
    nmi = 1'b1;
    tick();

    // BRK hijacked by an NMI edge in the same SYNC cycle.
    nmi = 1'b0; brk = 1'b1; sync = 1'b1;
    tick();
    sync = 1'b0; brk = 1'b0;
    chk("hijack_kind",  32'(v_kind),  32'd1);
    chk("hijack_vec",   32'(v_vec),   32'hFFFA);
    chk("hijack_bflag", 32'(v_bflag), 32'd1);
    ack_request();
    nmi = 1'b1;
    tick();

    // BRK without SYNC is ignored.
    brk = 1'b1;
    tick();
    brk = 1'b0;
    chk("brk_nosync", 32'(v_req), 32'd0);

    for (int i = 0; i < 10; i++) run_entry(i);

    // Ack held while stalled: no SET_I until RDY returns.
    brk = 1'b1; sync = 1'b1;
    tick();
    brk = 1'b0; sync = 1'b0;
    chk("stall_req", 32'(v_req), 32'd1);
    svc_ack = 1'b1; rdy = 1'b0;
    #1 chk("stall_no_seti", 32'(v_set_i), 32'd0);
    tick();
    chk("stall_hold1", 32'(v_req), 32'd1);
    tick();
    chk("stall_hold2", 32'(v_req), 32'd1);
    rdy = 1'b1;
    #1 chk("stall_seti", 32'(v_set_i), 32'd1);
    tick();
    svc_ack = 1'b0;
    chk("stall_done", 32'(v_req), 32'd0);
    tick();

    // Reset in the middle of an NMI request clears the pending NMI.
    nmi = 1'b0; sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("mid_req",  32'(v_req),  32'd1);
    chk("mid_kind", 32'(v_kind), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_ract", 32'(v_ract), 32'd1);
    chk("mid_req0", 32'(v_req),  32'd0);
    chk("mid_kind0", 32'(v_kind), 32'd0);
    rst_n = 1'b1; nmi = 1'b1;
    repeat (3) tick();
    chk("mid_rreq",  32'(v_req),  32'd1);
    chk("mid_rkind", 32'(v_kind), 32'd0);
    chk("mid_rvec",  32'(v_vec),  32'hFFFC);
    ack_request();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("mid_no_nmi", 32'(v_req), 32'd0);
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 7) == 0) nmi = ~nmi;
      irq      = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      irq_mask = 4'($urandom);
      i_flag   = ($urandom_range(0, 3) == 0);
      sync     = ($urandom_range(0, 2) == 0);
      brk      = ($urandom_range(0, 3) == 0);
      rdy      = ($urandom_range(0, 3) != 0);
      svc_ack  = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
